// File: rtl/wb_ifetch_data_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : processorci_wb_pkg
// Brief    : Shared Wishbone arbiter types and constants.
// Revision : 1.0 - initial release
// ============================================================================
package processorci_wb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } arb_state_t;

    localparam logic [1:0]  GRANT_I              = 2'b01;
    localparam logic [1:0]  GRANT_D              = 2'b10;
    localparam logic [31:0] DEFAULT_TIMEOUT_DATA = 32'hDEAD_BEEF;

endpackage
`default_nettype wire

// File: rtl/wb_ifetch_data_arbiter_watchdog.sv
`default_nettype none
// ============================================================================
// Module   : wb_watchdog_counter
// Brief    : Cycle counter that flags when LIMIT-1 is reached; LIMIT=0 disables.
// Revision : 1.0 - initial release
// ============================================================================
module wb_watchdog_counter #(
    parameter int unsigned LIMIT = 1024
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    input  logic enable_i,
    output logic hit_o
);

    generate
        if (LIMIT == 0) begin : g_disabled
            assign hit_o = 1'b0;
        end else begin : g_enabled
            localparam int unsigned CNT_W = (LIMIT > 1) ? $clog2(LIMIT) : 1;

            logic [CNT_W-1:0] count_q;
            logic             w_hit;

            assign w_hit = (count_q == CNT_W'(LIMIT - 1));
            assign hit_o = w_hit;

            // Saturate at the limit so a stuck enable cannot wrap back to zero.
            always_ff @(posedge clk_i) begin
                if (rst_i || clear_i) begin
                    count_q <= '0;
                end else if (enable_i && !w_hit) begin
                    count_q <= count_q + 1'b1;
                end
            end
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/wb_ifetch_data_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : wb_ifetch_data_arbiter
// Brief    : Round-robin Wishbone B4 classic arbiter, iport + dport onto core bus.
// Revision : 1.0 - initial release
// ============================================================================
module wb_ifetch_data_arbiter
    import processorci_wb_pkg::*;
#(
    parameter int unsigned           ADDR_WIDTH     = 32,
    parameter int unsigned           DATA_WIDTH     = 32,
    parameter int unsigned           TIMEOUT_CYCLES = 1024,
    parameter logic [DATA_WIDTH-1:0] TIMEOUT_DATA   = DATA_WIDTH'(DEFAULT_TIMEOUT_DATA)
) (
    input  logic                    wb_clk_i,
    input  logic                    wb_rst_i,

    input  logic [ADDR_WIDTH-1:0]   iport_wb_adr_i,
    input  logic                    iport_wb_cyc_i,
    input  logic                    iport_wb_stb_i,
    output logic [DATA_WIDTH-1:0]   iport_wb_dat_o,
    output logic                    iport_wb_ack_o,

    input  logic [ADDR_WIDTH-1:0]   dport_wb_adr_i,
    input  logic [DATA_WIDTH-1:0]   dport_wb_dat_i,
    output logic [DATA_WIDTH-1:0]   dport_wb_dat_o,
    input  logic                    dport_wb_cyc_i,
    input  logic                    dport_wb_stb_i,
    input  logic                    dport_wb_we_i,
    input  logic [DATA_WIDTH/8-1:0] dport_wb_sel_i,
    output logic                    dport_wb_ack_o,

    output logic                    core_cyc_o,
    output logic                    core_stb_o,
    output logic                    core_we_o,
    output logic [DATA_WIDTH/8-1:0] core_sel_o,
    output logic [ADDR_WIDTH-1:0]   core_addr_o,
    output logic [DATA_WIDTH-1:0]   core_data_o,
    input  logic [DATA_WIDTH-1:0]   core_data_i,
    input  logic                    core_ack_i,

    output logic [1:0]              grant_o,
    output logic                    timeout_o
);

    arb_state_t state_q, state_d;
    logic       last_d_q, last_d_d;   // 1 when dport held the most recent grant

    logic w_req_i, w_req_d;
    logic w_busy, w_own_cyc, w_wd_hit, w_fire, w_ack, w_done;

    assign w_req_i   = iport_wb_cyc_i & iport_wb_stb_i;
    assign w_req_d   = dport_wb_cyc_i & dport_wb_stb_i;
    assign w_busy    = (state_q != IDLE);
    assign w_own_cyc = (state_q == BUSY_D) ? dport_wb_cyc_i : iport_wb_cyc_i;

    // A real slave ack in the expiry cycle takes precedence over the watchdog.
    assign w_fire = w_busy & w_own_cyc & w_wd_hit & ~core_ack_i;
    assign w_ack  = w_busy & w_own_cyc & (core_ack_i | w_wd_hit);
    assign w_done = ~w_own_cyc | w_ack;

    wb_watchdog_counter #(
        .LIMIT    (TIMEOUT_CYCLES)
    ) u_wdog (
        .clk_i    (wb_clk_i),
        .rst_i    (wb_rst_i),
        .clear_i  (~w_busy),
        .enable_i (w_busy & ~core_ack_i),
        .hit_o    (w_wd_hit)
    );

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q  <= IDLE;
            last_d_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            last_d_q <= last_d_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        last_d_d = last_d_q;
        case (state_q)
            IDLE: begin
                if (w_req_i && w_req_d) begin
                    state_d  = last_d_q ? BUSY_I : BUSY_D;
                    last_d_d = ~last_d_q;
                end else if (w_req_i) begin
                    state_d  = BUSY_I;
                    last_d_d = 1'b0;
                end else if (w_req_d) begin
                    state_d  = BUSY_D;
                    last_d_d = 1'b1;
                end
            end
            BUSY_I, BUSY_D: begin
                if (w_done) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        core_cyc_o     = 1'b0;
        core_stb_o     = 1'b0;
        core_we_o      = 1'b0;
        core_sel_o     = '0;
        core_addr_o    = '0;
        core_data_o    = '0;
        iport_wb_ack_o = 1'b0;
        iport_wb_dat_o = '0;
        dport_wb_ack_o = 1'b0;
        dport_wb_dat_o = '0;
        grant_o        = 2'b00;
        timeout_o      = w_fire;
        case (state_q)
            BUSY_I: begin
                core_cyc_o     = iport_wb_cyc_i & ~w_fire;
                core_stb_o     = iport_wb_stb_i & ~w_fire;
                core_sel_o     = '1;
                core_addr_o    = iport_wb_adr_i;
                iport_wb_ack_o = w_ack;
                iport_wb_dat_o = w_fire ? TIMEOUT_DATA : core_data_i;
                grant_o        = GRANT_I;
            end
            BUSY_D: begin
                core_cyc_o     = dport_wb_cyc_i & ~w_fire;
                core_stb_o     = dport_wb_stb_i & ~w_fire;
                core_we_o      = dport_wb_we_i;
                core_sel_o     = dport_wb_sel_i;
                core_addr_o    = dport_wb_adr_i;
                core_data_o    = dport_wb_dat_i;
                dport_wb_ack_o = w_ack;
                dport_wb_dat_o = w_fire ? TIMEOUT_DATA : core_data_i;
                grant_o        = GRANT_D;
            end
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_wb_ifetch_data_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_ifetch_data_arbiter
// Brief    : Self-checking bench: directed vector table, fairness run, random model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wb_ifetch_data_arbiter;

    localparam int          TO   = 8;
    localparam logic [31:0] TDAT = 32'hDEAD_BEEF;

    logic        wb_clk_i, wb_rst_i;
    logic [31:0] iport_wb_adr_i, iport_wb_dat_o;
    logic        iport_wb_cyc_i, iport_wb_stb_i, iport_wb_ack_o;
    logic [31:0] dport_wb_adr_i, dport_wb_dat_i, dport_wb_dat_o;
    logic        dport_wb_cyc_i, dport_wb_stb_i, dport_wb_we_i, dport_wb_ack_o;
    logic [3:0]  dport_wb_sel_i, core_sel_o;
    logic        core_cyc_o, core_stb_o, core_we_o, core_ack_i, timeout_o;
    logic [31:0] core_addr_o, core_data_o, core_data_i;
    logic [1:0]  grant_o;

    int n_cmp = 0;
    int n_bad = 0;

    wb_ifetch_data_arbiter #(
        .ADDR_WIDTH     (32),
        .DATA_WIDTH     (32),
        .TIMEOUT_CYCLES (TO),
        .TIMEOUT_DATA   (TDAT)
    ) dut (
        .wb_clk_i       (wb_clk_i),
        .wb_rst_i       (wb_rst_i),
        .iport_wb_adr_i (iport_wb_adr_i),
        .iport_wb_cyc_i (iport_wb_cyc_i),
        .iport_wb_stb_i (iport_wb_stb_i),
        .iport_wb_dat_o (iport_wb_dat_o),
        .iport_wb_ack_o (iport_wb_ack_o),
        .dport_wb_adr_i (dport_wb_adr_i),
        .dport_wb_dat_i (dport_wb_dat_i),
        .dport_wb_dat_o (dport_wb_dat_o),
        .dport_wb_cyc_i (dport_wb_cyc_i),
        .dport_wb_stb_i (dport_wb_stb_i),
        .dport_wb_we_i  (dport_wb_we_i),
        .dport_wb_sel_i (dport_wb_sel_i),
        .dport_wb_ack_o (dport_wb_ack_o),
        .core_cyc_o     (core_cyc_o),
        .core_stb_o     (core_stb_o),
        .core_we_o      (core_we_o),
        .core_sel_o     (core_sel_o),
        .core_addr_o    (core_addr_o),
        .core_data_o    (core_data_o),
        .core_data_i    (core_data_i),
        .core_ack_i     (core_ack_i),
        .grant_o        (grant_o),
        .timeout_o      (timeout_o)
    );

    initial wb_clk_i = 1'b0;
    always #5 wb_clk_i = ~wb_clk_i;

    typedef struct {
        logic        rst, ic, dc, dwe, ack;
        logic [31:0] ia, da, dd, sdat;
        logic [3:0]  dsel;
        logic [1:0]  g;
        logic        ccyc, cwe;
        logic [31:0] caddr, cdat;
        logic [3:0]  csel;
        logic        iack, dack, tmo;
        logic [31:0] adat;
    } vec_t;

    vec_t tbl[44];

    function automatic vec_t mk(
        input logic rst, input logic ic, input logic [31:0] ia,
        input logic dc, input logic dwe, input logic [31:0] da, input logic [31:0] dd,
        input logic [3:0] dsel, input logic ack, input logic [31:0] sdat,
        input logic [1:0] g, input logic ccyc, input logic [31:0] caddr, input logic cwe,
        input logic [3:0] csel, input logic [31:0] cdat, input logic iack, input logic dack,
        input logic [31:0] adat, input logic tmo);
        vec_t v;
        v.rst = rst; v.ic = ic; v.ia = ia; v.dc = dc; v.dwe = dwe; v.da = da; v.dd = dd;
        v.dsel = dsel; v.ack = ack; v.sdat = sdat; v.g = g; v.ccyc = ccyc; v.caddr = caddr;
        v.cwe = cwe; v.csel = csel; v.cdat = cdat; v.iack = iack; v.dack = dack;
        v.adat = adat; v.tmo = tmo;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic check_exp(input string tag, input logic [1:0] g, input logic ccyc,
                             input logic cstb, input logic [31:0] caddr, input logic cwe,
                             input logic [3:0] csel, input logic [31:0] cdat,
                             input logic iack, input logic dack, input logic [31:0] adat,
                             input logic tmo);
        chk({tag, " grant"}, 32'(grant_o), 32'(g));
        chk({tag, " core_cyc"}, 32'(core_cyc_o), 32'(ccyc));
        chk({tag, " core_stb"}, 32'(core_stb_o), 32'(cstb));
        chk({tag, " iack"}, 32'(iport_wb_ack_o), 32'(iack));
        chk({tag, " dack"}, 32'(dport_wb_ack_o), 32'(dack));
        chk({tag, " timeout"}, 32'(timeout_o), 32'(tmo));
        if (ccyc) begin
            chk({tag, " core_addr"}, core_addr_o, caddr);
            chk({tag, " core_we"}, 32'(core_we_o), 32'(cwe));
            chk({tag, " core_sel"}, 32'(core_sel_o), 32'(csel));
            chk({tag, " core_wdata"}, core_data_o, cdat);
        end
        if (iack) chk({tag, " idat"}, iport_wb_dat_o, adat);
        if (dack) chk({tag, " ddat"}, dport_wb_dat_o, adat);
        if (g != 2'b01) chk({tag, " idat_zero"}, iport_wb_dat_o, 32'h0);
        if (g != 2'b10) chk({tag, " ddat_zero"}, dport_wb_dat_o, 32'h0);
    endtask

    task automatic drive(input vec_t v);
        wb_rst_i       = v.rst;
        iport_wb_cyc_i = v.ic;  iport_wb_stb_i = v.ic;  iport_wb_adr_i = v.ia;
        dport_wb_cyc_i = v.dc;  dport_wb_stb_i = v.dc;  dport_wb_we_i  = v.dwe;
        dport_wb_adr_i = v.da;  dport_wb_dat_i = v.dd;  dport_wb_sel_i = v.dsel;
        core_ack_i     = v.ack; core_data_i    = v.sdat;
    endtask

    // Reference model: who owns the bus, who was served last, cycles spent waiting.
    int   m_owner;   // 0 none, 1 iport, 2 dport
    int   m_last;
    int   m_age;
    logic m_ownc, m_ack, m_fire;

    task automatic model_check(input int cyc);
        logic [1:0]  g = 2'b00;
        logic        ccyc = 0, cstb = 0, cwe = 0, iack = 0, dack = 0;
        logic [3:0]  csel = 4'h0;
        logic [31:0] caddr = 0, cdat = 0, adat = 0;
        logic        owns = 0;
        m_ownc = 0; m_ack = 0; m_fire = 0;
        if (m_owner != 0) begin
            m_ownc = (m_owner == 1) ? iport_wb_cyc_i : dport_wb_cyc_i;
            owns   = (m_owner == 1) ? iport_wb_stb_i : dport_wb_stb_i;
            m_fire = m_ownc && (m_age == TO - 1) && !core_ack_i;
            m_ack  = m_ownc && (core_ack_i || m_fire);
            g      = (m_owner == 1) ? 2'b01 : 2'b10;
            ccyc   = m_ownc && !m_fire;
            cstb   = owns && !m_fire;
            caddr  = (m_owner == 1) ? iport_wb_adr_i : dport_wb_adr_i;
            cwe    = (m_owner == 2) ? dport_wb_we_i : 1'b0;
            csel   = (m_owner == 2) ? dport_wb_sel_i : 4'hF;
            cdat   = (m_owner == 2) ? dport_wb_dat_i : 32'h0;
            adat   = m_fire ? TDAT : core_data_i;
            iack   = (m_owner == 1) && m_ack;
            dack   = (m_owner == 2) && m_ack;
        end
        check_exp($sformatf("rnd%0d", cyc), g, ccyc, cstb, caddr, cwe, csel, cdat,
                  iack, dack, adat, m_fire);
    endtask

    task automatic model_edge();
        if (wb_rst_i) begin
            m_owner = 0; m_last = 1; m_age = 0;
        end else if (m_owner == 0) begin
            if (iport_wb_cyc_i && iport_wb_stb_i && dport_wb_cyc_i && dport_wb_stb_i)
                m_owner = (m_last == 1) ? 2 : 1;
            else if (iport_wb_cyc_i && iport_wb_stb_i) m_owner = 1;
            else if (dport_wb_cyc_i && dport_wb_stb_i) m_owner = 2;
            if (m_owner != 0) begin
                m_last = m_owner;
                m_age  = 0;
            end
        end else if (!m_ownc || m_ack) begin
            m_owner = 0;
        end else begin
            m_age++;
        end
    endtask

    initial begin
        vec_t z;
        int   k;
        int   ntx;
        logic ic, dc;

        z = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        k = 0;
        // iport-only fetch
        tbl[k++] = z;
        tbl[k++] = mk(0, 1, 32'h40, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[k++] = mk(0, 1, 32'h40, 0, 0, 0, 0, 0, 0, 0, 2'b01, 1, 32'h40, 0, 4'hF, 0, 0, 0, 0, 0);
        tbl[k++] = mk(0, 1, 32'h40, 0, 0, 0, 0, 0, 1, 32'h13, 2'b01, 1, 32'h40, 0, 4'hF, 0, 1, 0, 32'h13, 0);
        tbl[k++] = z;
        // contention straight after reset: dport, then iport, then dport
        tbl[k++] = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[k++] = mk(0, 1, 32'h80, 1, 1, 32'h1000, 32'hCAFEF00D, 4'h3, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[k++] = mk(0, 1, 32'h80, 1, 1, 32'h1000, 32'hCAFEF00D, 4'h3, 0, 0, 2'b10, 1, 32'h1000, 1, 4'h3, 32'hCAFEF00D, 0, 0, 0, 0);
        tbl[k++] = mk(0, 1, 32'h80, 1, 1, 32'h1000, 32'hCAFEF00D, 4'h3, 1, 0, 2'b10, 1, 32'h1000, 1, 4'h3, 32'hCAFEF00D, 0, 1, 0, 0);
        tbl[k++] = mk(0, 1, 32'h80, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[k++] = mk(0, 1, 32'h80, 0, 0, 0, 0, 0, 0, 0, 2'b01, 1, 32'h80, 0, 4'hF, 0, 0, 0, 0, 0);
        tbl[k++] = mk(0, 1, 32'h80, 0, 0, 0, 0, 0, 1, 32'h00112233, 2'b01, 1, 32'h80, 0, 4'hF, 0, 1, 0, 32'h00112233, 0);
        tbl[k++] = mk(0, 1, 32'h80, 1, 0, 32'h3000, 32'hCAFEF00D, 4'h3, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[k++] = mk(0, 1, 32'h80, 1, 0, 32'h3000, 32'hCAFEF00D, 4'h3, 1, 32'h55, 2'b10, 1, 32'h3000, 0, 4'h3, 32'hCAFEF00D, 0, 1, 32'h55, 0);
        tbl[k++] = z;
        // watchdog expiry on a never-acked dport read
        tbl[k++] = mk(0, 0, 0, 1, 0, 32'h2000, 0, 4'hF, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int j = 0; j < TO - 1; j++)
            tbl[k++] = mk(0, 0, 0, 1, 0, 32'h2000, 0, 4'hF, 0, 0, 2'b10, 1, 32'h2000, 0, 4'hF, 0, 0, 0, 0, 0);
        tbl[k++] = mk(0, 0, 0, 1, 0, 32'h2000, 0, 4'hF, 0, 32'hBAD, 2'b10, 0, 0, 0, 0, 0, 0, 1, TDAT, 1);
        tbl[k++] = z;
        // real ack in the expiry cycle wins
        tbl[k++] = mk(0, 0, 0, 1, 0, 32'h2004, 0, 4'hF, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int j = 0; j < TO - 1; j++)
            tbl[k++] = mk(0, 0, 0, 1, 0, 32'h2004, 0, 4'hF, 0, 0, 2'b10, 1, 32'h2004, 0, 4'hF, 0, 0, 0, 0, 0);
        tbl[k++] = mk(0, 0, 0, 1, 0, 32'h2004, 0, 4'hF, 1, 32'h12345678, 2'b10, 1, 32'h2004, 0, 4'hF, 0, 0, 1, 32'h12345678, 0);
        tbl[k++] = z;
        // reset mid BUSY_D, stray ack afterwards, then dport abort
        tbl[k++] = mk(0, 0, 0, 1, 0, 32'h2008, 0, 4'hF, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[k++] = mk(0, 0, 0, 1, 0, 32'h2008, 0, 4'hF, 0, 0, 2'b10, 1, 32'h2008, 0, 4'hF, 0, 0, 0, 0, 0);
        tbl[k++] = mk(1, 0, 0, 1, 0, 32'h2008, 0, 4'hF, 0, 0, 2'b10, 1, 32'h2008, 0, 4'hF, 0, 0, 0, 0, 0);
        tbl[k++] = mk(0, 0, 0, 1, 0, 32'h2008, 0, 4'hF, 1, 32'h99, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[k++] = mk(0, 0, 0, 0, 0, 32'h2008, 0, 4'hF, 0, 0, 2'b10, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        // iport abort
        tbl[k++] = mk(0, 1, 32'h44, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[k++] = mk(0, 1, 32'h44, 0, 0, 0, 0, 0, 0, 0, 2'b01, 1, 32'h44, 0, 4'hF, 0, 0, 0, 0, 0);
        tbl[k++] = mk(0, 0, 32'h44, 0, 0, 0, 0, 0, 0, 0, 2'b01, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[k++] = z;

        z.rst = 1'b1;
        drive(z);
        repeat (2) @(posedge wb_clk_i);
        #1;

        for (int i = 0; i < k; i++) begin
            drive(tbl[i]);
            #4;
            check_exp($sformatf("row%0d", i), tbl[i].g, tbl[i].ccyc, tbl[i].ccyc, tbl[i].caddr,
                      tbl[i].cwe, tbl[i].csel, tbl[i].cdat, tbl[i].iack, tbl[i].dack,
                      tbl[i].adat, tbl[i].tmo);
            @(posedge wb_clk_i);
            #1;
        end

        // Fairness: both masters always requesting, slave always acking
        z = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        drive(z);
        @(posedge wb_clk_i);
        #1;
        z = mk(0, 1, 32'h100, 1, 0, 32'h4000, 0, 4'hF, 1, 32'h77, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        drive(z);
        ntx = 0;
        for (int c = 0; c < 40 && ntx < 16; c++) begin
            #4;
            if (grant_o != 2'b00) begin
                chk($sformatf("rr_tx%0d grant", ntx), 32'(grant_o),
                    (ntx % 2 == 0) ? 32'h2 : 32'h1);
                ntx++;
            end
            @(posedge wb_clk_i);
            #1;
        end
        chk("rr transaction count", ntx, 16);

        // Randomised run against the reference model
        m_owner = 0; m_last = 1; m_age = 0;
        wb_rst_i = 1'b1;
        @(posedge wb_clk_i);
        #1;
        ic = 0;
        dc = 0;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 5) == 0) ic = ~ic;
            if ($urandom_range(0, 5) == 0) dc = ~dc;
            wb_rst_i       = ($urandom_range(0, 255) == 0);
            iport_wb_cyc_i = ic;
            iport_wb_stb_i = ic && ($urandom_range(0, 7) != 0);
            iport_wb_adr_i = $urandom;
            dport_wb_cyc_i = dc;
            dport_wb_stb_i = dc && ($urandom_range(0, 7) != 0);
            dport_wb_we_i  = $urandom_range(0, 1) == 1;
            dport_wb_adr_i = $urandom;
            dport_wb_dat_i = $urandom;
            dport_wb_sel_i = 4'($urandom);
            core_ack_i     = ($urandom_range(0, 11) == 0);
            core_data_i    = $urandom;
            #4;
            model_check(c);
            @(posedge wb_clk_i);
            model_edge();
            #1;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
